logo_motion_ctrl: RTL

- Per-frame motion engine for the bouncing screensaver logo.
- Sits directly upstream of the ROM pixel renderer inside tt_um_rom_vga_screensaver.
- Consumes a one-cycle frame tick from the VGA timing generator.
- Produces the logo's top-left position, the current palette index, and bounce/corner event pulses used for colour changes and effects.

---
 rtl/logo_motion_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/logo_motion_ctrl.sv
// Bouncing-logo motion engine: per-frame position, direction, palette, events.
// Define LOGO_CORNER_HOLD_EN to freeze and flash the logo after a corner hit.
module logo_motion_ctrl #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOGO_W      = 128,
  parameter int LOGO_H      = 64,
  parameter int STEP        = 1,
  parameter int X_INIT      = 0,
  parameter int Y_INIT      = 0,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       pause,
  output logic [9:0] logo_x,
  output logic [9:0] logo_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic [2:0] color_idx,
  output logic       bounce,
  output logic       corner,
  output logic       holding
);

  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - LOGO_W);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - LOGO_H);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [9:0]  X_LIM  = X_MAX[9:0];
  localparam logic [9:0]  Y_LIM  = Y_MAX[9:0];
  localparam logic [9:0]  STEP_N = STEP_W[9:0];
  localparam logic [15:0] HOLD_LD = 16'(HOLD_FRAMES - 1);

`ifdef LOGO_CORNER_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  typedef enum logic {MOVE, HOLD} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [9:0]  x_nxt, y_nxt;
  logic        dx_nxt, dy_nxt;
  logic [2:0]  color_nxt, color_adv;
  logic        bounce_nxt, corner_nxt;
  logic [10:0] sum_x, sum_y;
  logic [9:0]  x_mv, y_mv;
  logic        dx_mv, dy_mv;
  logic        hit_x, hit_y, upd;

  assign upd       = frame_tick & ~pause;
  assign color_adv = (color_idx == 3'd7) ? 3'd1 : color_idx + 3'd1;
  assign holding   = HOLD_EN && (state == HOLD);

  // 11-bit sums so the wall compare can never wrap
  always_comb begin
    sum_x = {1'b0, logo_x} + STEP_W;
    sum_y = {1'b0, logo_y} + STEP_W;
    x_mv  = logo_x;
    y_mv  = logo_y;
    dx_mv = dir_x;
    dy_mv = dir_y;
    hit_x = 1'b0;
    hit_y = 1'b0;
    if (dir_x) begin
      if (sum_x >= X_MAX) begin
        x_mv  = X_LIM;
        dx_mv = 1'b0;
        hit_x = 1'b1;
      end else begin
        x_mv = sum_x[9:0];
      end
    end else if ({1'b0, logo_x} <= STEP_W) begin
      x_mv  = '0;
      dx_mv = 1'b1;
      hit_x = 1'b1;
    end else begin
      x_mv = logo_x - STEP_N;
    end
    if (dir_y) begin
      if (sum_y >= Y_MAX) begin
        y_mv  = Y_LIM;
        dy_mv = 1'b0;
        hit_y = 1'b1;
      end else begin
        y_mv = sum_y[9:0];
      end
    end else if ({1'b0, logo_y} <= STEP_W) begin
      y_mv  = '0;
      dy_mv = 1'b1;
      hit_y = 1'b1;
    end else begin
      y_mv = logo_y - STEP_N;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    x_nxt      = logo_x;
    y_nxt      = logo_y;
    dx_nxt     = dir_x;
    dy_nxt     = dir_y;
    color_nxt  = color_idx;
    bounce_nxt = 1'b0;
    corner_nxt = 1'b0;
    unique case (state)
      MOVE: begin
        if (upd) begin
          x_nxt      = x_mv;
          y_nxt      = y_mv;
          dx_nxt     = dx_mv;
          dy_nxt     = dy_mv;
          bounce_nxt = hit_x | hit_y;
          corner_nxt = hit_x & hit_y;
          if (hit_x | hit_y) color_nxt = color_adv;
          if (HOLD_EN && hit_x && hit_y) begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_LD;
          end
        end
      end
      HOLD: begin
        if (upd) begin
          color_nxt = color_adv;
          if (cnt == '0) state_nxt = MOVE;
          else           cnt_nxt   = cnt - 16'd1;
        end
      end
      default: state_nxt = MOVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MOVE;
      cnt       <= '0;
      logo_x    <= 10'(X_INIT);
      logo_y    <= 10'(Y_INIT);
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      color_idx <= 3'd1;
      bounce    <= 1'b0;
      corner    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      logo_x    <= x_nxt;
      logo_y    <= y_nxt;
      dir_x     <= dx_nxt;
      dir_y     <= dy_nxt;
      color_idx <= color_nxt;
      bounce    <= bounce_nxt;
      corner    <= corner_nxt;
    end
  end

endmodule
